// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// alu_pkg : opcode encodings and pipeline constants of the shared 32-bit ALU
// Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

   localparam int WIDTH   = 32;
   localparam int ALU_LAT = 2;
   localparam int OPC_W   = 4;
   localparam int SHIFT_W = 5;

   localparam logic [OPC_W-1:0] ADD = 4'd0;
   localparam logic [OPC_W-1:0] SUB = 4'd1;
   localparam logic [OPC_W-1:0] MUL = 4'd2;
   localparam logic [OPC_W-1:0] SLT = 4'd3;
   localparam logic [OPC_W-1:0] ROR = 4'd4;
   localparam logic [OPC_W-1:0] SNE = 4'd5;
   localparam logic [OPC_W-1:0] AND = 4'd6;
   localparam logic [OPC_W-1:0] SGE = 4'd7;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// rr_arbiter : combinational round-robin pick, first eligible index after last
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
   parameter int N  = 4,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  eligible,
   input  logic [IW-1:0] last,
   output logic [N-1:0]  grant_onehot,
   output logic [IW-1:0] grant_idx,
   output logic          grant_any
);

   logic [N-1:0]  w_above;
   logic [N-1:0]  w_hi;
   logic [IW-1:0] w_hi_idx;
   logic [IW-1:0] w_lo_idx;
   logic          w_hi_any;
   logic          w_lo_any;

   // Indices strictly above last win first; otherwise wrap to the lowest eligible.
   always_comb begin
      w_above = '0;
      for (int i = 0; i < N; i++) begin
         w_above[i] = (IW'(i) > last);
      end
   end

   assign w_hi = eligible & w_above;

   always_comb begin
      w_hi_any = 1'b0;
      w_hi_idx = '0;
      w_lo_any = 1'b0;
      w_lo_idx = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (w_hi[i]) begin
            w_hi_any = 1'b1;
            w_hi_idx = IW'(i);
         end
         if (eligible[i]) begin
            w_lo_any = 1'b1;
            w_lo_idx = IW'(i);
         end
      end
   end

   assign grant_any    = w_hi_any | w_lo_any;
   assign grant_idx    = w_hi_any ? w_hi_idx : w_lo_idx;
   assign grant_onehot = grant_any ? (N'(1) << grant_idx) : '0;

endmodule
`default_nettype wire

// File: rtl/alu_rr_scheduler.sv
`default_nettype none
// ============================================================================
// alu_rr_scheduler : round-robin sharing of one pipelined ALU with tag return
// Revision : 1.0 - initial release
// ============================================================================
module alu_rr_scheduler #(
   parameter int NREQ    = 4,
   parameter int WIDTH   = alu_pkg::WIDTH,
   parameter int ALU_LAT = alu_pkg::ALU_LAT
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic [NREQ-1:0]                   req_valid,
   output logic [NREQ-1:0]                   req_ready,
   input  logic [alu_pkg::OPC_W*NREQ-1:0]    req_opcode,
   input  logic [WIDTH*NREQ-1:0]             req_a,
   input  logic [WIDTH*NREQ-1:0]             req_b,
   input  logic [alu_pkg::SHIFT_W*NREQ-1:0]  req_shift,
   output logic [alu_pkg::OPC_W-1:0]         alu_opcode,
   output logic [WIDTH-1:0]                  alu_in1,
   output logic [WIDTH-1:0]                  alu_in2,
   output logic [alu_pkg::SHIFT_W-1:0]       alu_shift,
   input  logic [WIDTH-1:0]                  alu_result,
   input  logic                              alu_carry,
   input  logic                              alu_zero,
   input  logic                              alu_sign,
   output logic [NREQ-1:0]                   rsp_valid,
   output logic [WIDTH-1:0]                  rsp_result,
   output logic                              rsp_carry,
   output logic                              rsp_zero,
   output logic                              rsp_sign,
   output logic [NREQ-1:0]                   busy,
   output logic [31:0]                       issue_count
);

   import alu_pkg::*;

   localparam int              c_idx_w = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [NREQ-1:0] c_one   = NREQ'(1);

   logic [OPC_W-1:0]   w_op [NREQ];
   logic [WIDTH-1:0]   w_a  [NREQ];
   logic [WIDTH-1:0]   w_b  [NREQ];
   logic [SHIFT_W-1:0] w_sh [NREQ];

   logic [NREQ-1:0]    r_busy;
   logic [c_idx_w-1:0] r_last;
   logic [31:0]        r_issue_count;
   logic               r_tag_vld [ALU_LAT];
   logic [c_idx_w-1:0] r_tag_idx [ALU_LAT];

   logic [NREQ-1:0]    w_clr;
   logic [NREQ-1:0]    w_eligible;
   logic [NREQ-1:0]    w_grant_oh;
   logic [c_idx_w-1:0] w_grant_idx;
   logic               w_grant_any;
   logic               w_issue;

   generate
      for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
         assign w_op[gi] = req_opcode[OPC_W*gi +: OPC_W];
         assign w_a[gi]  = req_a[WIDTH*gi +: WIDTH];
         assign w_b[gi]  = req_b[WIDTH*gi +: WIDTH];
         assign w_sh[gi] = req_shift[SHIFT_W*gi +: SHIFT_W];
      end
   endgenerate

   // A returning tag frees its requester in the same cycle it may be re-granted.
   assign w_clr      = r_tag_vld[ALU_LAT-1] ? (c_one << r_tag_idx[ALU_LAT-1]) : '0;
   assign w_eligible = req_valid & (~r_busy | w_clr);

   rr_arbiter #(
      .N  (NREQ),
      .IW (c_idx_w)
   ) u_arb (
      .eligible     (w_eligible),
      .last         (r_last),
      .grant_onehot (w_grant_oh),
      .grant_idx    (w_grant_idx),
      .grant_any    (w_grant_any)
   );

   // Grant is masked while reset is held so ALU-side outputs read zero.
   assign w_issue    = w_grant_any & rst_n;
   assign req_ready  = w_issue ? w_grant_oh : '0;
   assign alu_opcode = w_issue ? w_op[w_grant_idx] : '0;
   assign alu_in1    = w_issue ? w_a[w_grant_idx]  : '0;
   assign alu_in2    = w_issue ? w_b[w_grant_idx]  : '0;
   assign alu_shift  = w_issue ? w_sh[w_grant_idx] : '0;

   assign rsp_valid   = w_clr;
   assign rsp_result  = alu_result;
   assign rsp_carry   = alu_carry;
   assign rsp_zero    = alu_zero;
   assign rsp_sign    = alu_sign;
   assign busy        = r_busy;
   assign issue_count = r_issue_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_busy        <= '0;
         r_last        <= c_idx_w'(NREQ - 1);
         r_issue_count <= '0;
      end else begin
         r_busy <= (r_busy & ~w_clr) | req_ready;
         if (w_issue) begin
            r_last        <= w_grant_idx;
            r_issue_count <= r_issue_count + 32'd1;
         end
      end
   end

   // Tag pipeline mirrors the ALU latency so results map back to their issuer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < ALU_LAT; s++) begin
            r_tag_vld[s] <= 1'b0;
            r_tag_idx[s] <= '0;
         end
      end else begin
         r_tag_vld[0] <= w_issue;
         r_tag_idx[0] <= w_grant_idx;
         for (int s = 1; s < ALU_LAT; s++) begin
            r_tag_vld[s] <= r_tag_vld[s-1];
            r_tag_idx[s] <= r_tag_idx[s-1];
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_alu_rr_scheduler.sv
`default_nettype none
// tb_alu_rr_scheduler : scoreboard bench with a behavioural 2-stage ALU attached
module tb_alu_rr_scheduler;
   import alu_pkg::*;

   localparam int NREQ = 4;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic [NREQ-1:0]   req_valid, req_ready, rsp_valid, busy;
   logic [4*NREQ-1:0] req_opcode;
   logic [32*NREQ-1:0] req_a, req_b;
   logic [5*NREQ-1:0] req_shift;
   logic [3:0]        alu_opcode;
   logic [31:0]       alu_in1, alu_in2, alu_result, rsp_result, issue_count;
   logic [4:0]        alu_shift;
   logic              alu_carry, alu_zero, alu_sign, rsp_carry, rsp_zero, rsp_sign;

   logic        s_vld [NREQ];
   logic [3:0]  s_op  [NREQ];
   logic [31:0] s_a   [NREQ];
   logic [31:0] s_b   [NREQ];
   logic [4:0]  s_sh  [NREQ];

   always_comb begin
      req_valid  = '0;
      req_opcode = '0;
      req_a      = '0;
      req_b      = '0;
      req_shift  = '0;
      for (int i = 0; i < NREQ; i++) begin
         req_valid[i]         = s_vld[i];
         req_opcode[4*i +: 4] = s_op[i];
         req_a[32*i +: 32]    = s_a[i];
         req_b[32*i +: 32]    = s_b[i];
         req_shift[5*i +: 5]  = s_sh[i];
      end
   end

   alu_rr_scheduler #(.NREQ(NREQ), .WIDTH(32), .ALU_LAT(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_opcode(req_opcode), .req_a(req_a), .req_b(req_b), .req_shift(req_shift),
      .alu_opcode(alu_opcode), .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_shift(alu_shift),
      .alu_result(alu_result), .alu_carry(alu_carry), .alu_zero(alu_zero), .alu_sign(alu_sign),
      .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_carry(rsp_carry),
      .rsp_zero(rsp_zero), .rsp_sign(rsp_sign),
      .busy(busy), .issue_count(issue_count)
   );

   function automatic void alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                   input logic [4:0] sh, output logic [31:0] res,
                                   output logic cy, output logic upd);
      logic [32:0] sum;
      logic [63:0] rot;
      res = '0;
      cy  = 1'b0;
      upd = 1'b0;
      sum = {1'b0, a} + {1'b0, b};
      rot = {a, a} >> sh;
      case (op)
         ADD: begin res = sum[31:0]; cy = sum[32]; upd = 1'b1; end
         SUB: begin res = a - b; cy = (a < b); upd = 1'b1; end
         MUL: res = a * b;
         SLT: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         ROR: res = rot[31:0];
         SNE: res = (a != b) ? 32'd1 : 32'd0;
         AND: res = a & b;
         SGE: res = ($signed(a) >= $signed(b)) ? 32'd1 : 32'd0;
         default: res = '0;
      endcase
   endfunction

   // Behavioural ALU: operands registered at issue edge, result one edge later.
   logic [3:0]  a1_op;
   logic [31:0] a1_a, a1_b, a2_res;
   logic [4:0]  a1_sh;
   logic        a2_cy;
   always @(posedge clk or negedge rst_n) begin : alu_model
      logic [31:0] t_res;
      logic        t_cy, t_upd;
      if (!rst_n) begin
         a1_op <= '0; a1_a <= '0; a1_b <= '0; a1_sh <= '0;
         a2_res <= '0; a2_cy <= 1'b0;
      end else begin
         alu_ref(a1_op, a1_a, a1_b, a1_sh, t_res, t_cy, t_upd);
         a1_op <= alu_opcode; a1_a <= alu_in1; a1_b <= alu_in2; a1_sh <= alu_shift;
         a2_res <= t_res;
         if (t_upd) a2_cy <= t_cy;
      end
   end
   assign alu_result = a2_res;
   assign alu_carry  = a2_cy;
   assign alu_zero   = (a2_res == 32'd0);
   assign alu_sign   = a2_res[31];

   typedef struct packed {
      logic [31:0] res;
      logic        cy;
      logic        chk_cy;
   } exp_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_err = 0;

   logic [NREQ-1:0] m_busy;
   int              m_last;
   logic [31:0]     m_cnt;
   logic            m_vld [2];
   int              m_idx [2];

   // Cycle model: predicts grants, busy and counter; pushes expected results, pops on strobe.
   always @(negedge clk) begin : monitor
      logic [NREQ-1:0] clr, elig, exp_ready;
      int              g;
      exp_t            e;
      logic [31:0]     r;
      logic            c, u;
      if (rst_n !== 1'b1) begin
         m_busy = '0; m_last = NREQ - 1; m_cnt = '0;
         m_vld[0] = 1'b0; m_vld[1] = 1'b0; m_idx[0] = 0; m_idx[1] = 0;
         sb.delete();
      end else begin
         clr = m_vld[1] ? (4'b0001 << m_idx[1]) : 4'b0000;
         n_vec++;
         if (rsp_valid !== clr) begin
            n_err++; $display("FAIL sb_rsp_valid: got %b expected %b", rsp_valid, clr);
         end
         if (m_vld[1]) begin
            if (sb.size() == 0) begin
               n_err++; $display("FAIL sb_underflow: response with no expected entry");
            end else begin
               e = sb.pop_front();
               n_vec++;
               if (rsp_result !== e.res || rsp_zero !== (e.res == 32'd0) || rsp_sign !== e.res[31]) begin
                  n_err++;
                  $display("FAIL sb_result: got %h z%b s%b expected %h", rsp_result, rsp_zero, rsp_sign, e.res);
               end
               if (e.chk_cy) begin
                  n_vec++;
                  if (rsp_carry !== e.cy) begin
                     n_err++; $display("FAIL sb_carry: got %b expected %b", rsp_carry, e.cy);
                  end
               end
            end
         end
         elig = req_valid & (~m_busy | clr);
         g = -1;
         for (int off = 1; off <= NREQ; off++) begin
            if (g < 0 && elig[(m_last + off) % NREQ]) g = (m_last + off) % NREQ;
         end
         exp_ready = (g >= 0) ? (4'b0001 << g) : 4'b0000;
         n_vec++;
         if (req_ready !== exp_ready) begin
            n_err++; $display("FAIL sb_req_ready: got %b expected %b", req_ready, exp_ready);
         end
         n_vec++;
         if (busy !== m_busy) begin
            n_err++; $display("FAIL sb_busy: got %b expected %b", busy, m_busy);
         end
         n_vec++;
         if (issue_count !== m_cnt) begin
            n_err++; $display("FAIL sb_issue_count: got %0d expected %0d", issue_count, m_cnt);
         end
         n_vec++;
         if (g >= 0) begin
            if (alu_opcode !== s_op[g] || alu_in1 !== s_a[g] || alu_in2 !== s_b[g] || alu_shift !== s_sh[g]) begin
               n_err++;
               $display("FAIL sb_alu_inputs: got op%h %h %h sh%0d expected op%h %h %h sh%0d",
                        alu_opcode, alu_in1, alu_in2, alu_shift, s_op[g], s_a[g], s_b[g], s_sh[g]);
            end
            alu_ref(s_op[g], s_a[g], s_b[g], s_sh[g], r, c, u);
            e.res = r; e.cy = c; e.chk_cy = u;
            sb.push_back(e);
            m_last = g;
            m_cnt  = m_cnt + 32'd1;
         end else begin
            if ({alu_opcode, alu_in1, alu_in2, alu_shift} !== '0) begin
               n_err++;
               $display("FAIL sb_alu_idle: got op%h %h %h sh%0d expected zeros", alu_opcode, alu_in1, alu_in2, alu_shift);
            end
         end
         m_busy   = (m_busy & ~clr) | exp_ready;
         m_vld[1] = m_vld[0];
         m_idx[1] = m_idx[0];
         m_vld[0] = (g >= 0);
         m_idx[0] = (g >= 0) ? g : 0;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_reqs();
      for (int i = 0; i < NREQ; i++) begin
         s_vld[i] = 1'b0; s_op[i] = '0; s_a[i] = '0; s_b[i] = '0; s_sh[i] = '0;
      end
   endtask

   task automatic set_req(input int i, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] sh);
      s_vld[i] = 1'b1; s_op[i] = op; s_a[i] = a; s_b[i] = b; s_sh[i] = sh;
   endtask

   task automatic reset_dut();
      step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      clear_reqs();
      for (int i = 0; i < NREQ; i++) set_req(i, SUB, 32'h1234 + i, 32'h77, 5'd3);
      @(negedge clk);
      n_vec++;
      if (req_ready !== 4'b0 || rsp_valid !== 4'b0 || busy !== 4'b0 || issue_count !== 32'd0) begin
         n_err++;
         $display("FAIL reset_state: got ready %b rsp %b busy %b cnt %0d expected all zero",
                  req_ready, rsp_valid, busy, issue_count);
      end
      n_vec++;
      if ({alu_opcode, alu_in1, alu_in2, alu_shift} !== '0) begin
         n_err++; $display("FAIL reset_alu_side: got op%h %h %h expected zeros", alu_opcode, alu_in1, alu_in2);
      end
      clear_reqs();
      step();
      rst_n = 1'b1;
   endtask

   task automatic test_single_add();
      set_req(2, ADD, 32'hFFFF_FFFF, 32'd1, 5'd0);
      @(negedge clk);
      n_vec++;
      if (req_ready !== 4'b0100) begin
         n_err++; $display("FAIL add_ready: got %b expected 0100", req_ready);
      end
      step();
      clear_reqs();
      step();
      @(negedge clk);
      n_vec++;
      if (rsp_valid !== 4'b0100 || rsp_result !== 32'd0 || rsp_carry !== 1'b1 || rsp_zero !== 1'b1) begin
         n_err++;
         $display("FAIL add_response: got v%b %h c%b z%b expected v0100 00000000 c1 z1",
                  rsp_valid, rsp_result, rsp_carry, rsp_zero);
      end
      step();
   endtask

   task automatic test_all_valid();
      logic [3:0] exp_seq;
      reset_dut();
      set_req(0, ADD, 32'd10, 32'd20, 5'd0);
      set_req(1, SLT, 32'hFFFF_FFFF, 32'd1, 5'd0);
      set_req(2, 4'd9, 32'd55, 32'd66, 5'd7);
      set_req(3, SGE, 32'd5, 32'd5, 5'd0);
      for (int k = 0; k < 8; k++) begin
         exp_seq = 4'b0001 << (k % 4);
         @(negedge clk);
         n_vec++;
         if (req_ready !== exp_seq) begin
            n_err++; $display("FAIL rr_grant_%0d: got %b expected %b", k, req_ready, exp_seq);
         end
         step();
      end
      clear_reqs();
      for (int k = 0; k < 3; k++) step();
      @(negedge clk);
      n_vec++;
      if (issue_count !== 32'd8 || busy !== 4'b0) begin
         n_err++; $display("FAIL rr_count: got %0d busy %b expected 8 busy 0000", issue_count, busy);
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0] exp_rdy;
      reset_dut();
      set_req(1, MUL, 32'd7, 32'd6, 5'd0);
      for (int k = 0; k < 8; k++) begin
         exp_rdy = (k % 2 == 0) ? 4'b0010 : 4'b0000;
         @(negedge clk);
         n_vec++;
         if (req_ready !== exp_rdy) begin
            n_err++; $display("FAIL b2b_ready_%0d: got %b expected %b", k, req_ready, exp_rdy);
         end
         if (k >= 2 && k % 2 == 0) begin
            n_vec++;
            if (rsp_valid !== 4'b0010 || rsp_result !== 32'd42) begin
               n_err++; $display("FAIL b2b_result_%0d: got v%b %0d expected v0010 42", k, rsp_valid, rsp_result);
            end
         end
         step();
      end
      clear_reqs();
      for (int k = 0; k < 3; k++) step();
   endtask

   task automatic test_two_reqs();
      reset_dut();
      set_req(0, SUB, 32'd3, 32'd5, 5'd0);
      @(negedge clk);
      n_vec++;
      if (req_ready !== 4'b0001) begin
         n_err++; $display("FAIL two_ready0: got %b expected 0001", req_ready);
      end
      step();
      clear_reqs();
      set_req(3, AND, 32'h0000_F0F0, 32'h0000_0FF0, 5'd0);
      @(negedge clk);
      n_vec++;
      if (req_ready !== 4'b1000) begin
         n_err++; $display("FAIL two_ready3: got %b expected 1000", req_ready);
      end
      step();
      clear_reqs();
      @(negedge clk);
      n_vec++;
      if (rsp_valid !== 4'b0001 || rsp_result !== 32'hFFFF_FFFE || rsp_carry !== 1'b1 || rsp_sign !== 1'b1) begin
         n_err++;
         $display("FAIL two_sub_rsp: got v%b %h c%b s%b expected v0001 fffffffe c1 s1",
                  rsp_valid, rsp_result, rsp_carry, rsp_sign);
      end
      step();
      @(negedge clk);
      n_vec++;
      if (rsp_valid !== 4'b1000 || rsp_result !== 32'h0000_00F0) begin
         n_err++; $display("FAIL two_and_rsp: got v%b %h expected v1000 000000f0", rsp_valid, rsp_result);
      end
      step();
   endtask

   task automatic test_ror();
      set_req(1, ROR, 32'h0000_0001, 32'd0, 5'd1);
      @(negedge clk);
      n_vec++;
      if (req_ready !== 4'b0010) begin
         n_err++; $display("FAIL ror_ready: got %b expected 0010", req_ready);
      end
      step();
      clear_reqs();
      step();
      @(negedge clk);
      n_vec++;
      if (rsp_valid !== 4'b0010 || rsp_result !== 32'h8000_0000) begin
         n_err++; $display("FAIL ror_rsp: got v%b %h expected v0010 80000000", rsp_valid, rsp_result);
      end
      step();
   endtask

   task automatic test_midflight_reset();
      reset_dut();
      set_req(0, ADD, 32'd1, 32'd2, 5'd0);
      step();
      clear_reqs();
      set_req(1, ADD, 32'd3, 32'd4, 5'd0);
      step();
      clear_reqs();
      rst_n = 1'b0;
      @(negedge clk);
      n_vec++;
      if (rsp_valid !== 4'b0 || busy !== 4'b0 || issue_count !== 32'd0) begin
         n_err++;
         $display("FAIL flush_during: got rsp %b busy %b cnt %0d expected zeros", rsp_valid, busy, issue_count);
      end
      step();
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         n_vec++;
         if (rsp_valid !== 4'b0 || busy !== 4'b0) begin
            n_err++; $display("FAIL flush_after_%0d: got rsp %b busy %b expected 0000", k, rsp_valid, busy);
         end
         step();
      end
      for (int i = 0; i < NREQ; i++) set_req(i, SNE, 32'd1, 32'd2, 5'd0);
      @(negedge clk);
      n_vec++;
      if (req_ready !== 4'b0001 || issue_count !== 32'd0) begin
         n_err++; $display("FAIL flush_regrant: got %b cnt %0d expected 0001 cnt 0", req_ready, issue_count);
      end
      step();
      clear_reqs();
      for (int k = 0; k < 3; k++) step();
      @(negedge clk);
      n_vec++;
      if (sb.size() != 0) begin
         n_err++; $display("FAIL sb_drain: got %0d entries expected 0", sb.size());
      end
   endtask

   initial begin
      test_reset();
      test_single_add();
      test_all_valid();
      test_back_to_back();
      test_two_reqs();
      test_ror();
      test_midflight_reset();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
